// File: rtl/carry_event_timer_pkg.sv
// Shared definitions for the carry event timer stages.
// Holds the state encoding and the nibble bit-order helper.
// No logic; pure types and functions.
package carry_event_timer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // The counter nibble arrives as [0:3] with bit 0 the LSB; a plain
  // assignment to a [3:0] vector would reverse it, so index explicitly.
  function automatic logic [3:0] nib_val(input logic [0:3] n);
    return {n[3], n[2], n[1], n[0]};
  endfunction

endpackage

// File: rtl/carry_event_timer_if.sv
// Bundle between the counter slice, the timer and the status logic.
// Wires only, no latency.
// No backpressure; all strobes are single-cycle pulses.
interface carry_event_timer_if #(parameter int WIDTH = 8);

  logic             carry_in;
  logic [0:3]       nibble_in;
  logic             enable;
  logic             start;
  logic             stop;
  logic             oneshot;
  logic [WIDTH-1:0] period;
  logic             irq_ack;
  logic             capture_req;
  logic [WIDTH-1:0] ext_count;
  logic             busy;
  logic             tick;
  logic             irq;
  logic             missed;
  logic [WIDTH+3:0] capture;
  logic             capture_vld;

  modport master (
    output carry_in, nibble_in, enable, start, stop, oneshot, period,
           irq_ack, capture_req,
    input  ext_count, busy, tick, irq, missed, capture, capture_vld
  );

  modport slave (
    input  carry_in, nibble_in, enable, start, stop, oneshot, period,
           irq_ack, capture_req,
    output ext_count, busy, tick, irq, missed, capture, capture_vld
  );

endinterface

// File: rtl/carry_event_timer_irq_latch.sv
// Sticky interrupt with acknowledge plus a sticky missed-event flag.
// Latency: one cycle from set/ack to irq/missed.
// No backpressure; set always lands, and set beats a coincident ack.
module irq_latch (
  input  logic clock,
  input  logic clear,
  input  logic set,
  input  logic ack,
  output logic irq,
  output logic missed
);

  // An ack always clears missed; a set arriving with an ack re-raises irq
  // but is not a miss, since software is servicing the previous one.
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      irq    <= 1'b0;
      missed <= 1'b0;
    end else begin
      irq    <= set | (irq & ~ack);
      missed <= ~ack & (missed | (set & irq));
    end
  end

endmodule

// File: rtl/carry_event_timer.sv
// Extends the 4-bit counter by WIDTH bits, ticks on period match, captures timestamps.
// Latency: one cycle from a sampled carry/start/stop/capture_req to outputs.
// No backpressure; events outside RUN are dropped, capture requests always served.
module carry_event_timer
  import carry_event_timer_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input logic                clock,
  input logic                clear,
  carry_event_timer_if.slave bus
);

  state_t           state;
  state_t           state_nx;
  logic [WIDTH-1:0] period_q;
  logic             oneshot_q;
  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_nx;
  logic             tick_q;
  logic             busy_q;
  logic [WIDTH+3:0] cap_q;
  logic             cap_vld_q;
  logic             ev;
  logic             hit;
  logic             arm;

  assign ev  = bus.carry_in & bus.enable & (state == ST_RUN);
  assign hit = ev & (cnt_q == period_q);
  // Stop wins over start; start while running is ignored.
  assign arm = bus.start & ~bus.stop & ((state == ST_IDLE) | (state == ST_DONE));

  // State register.
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) state <= ST_IDLE;
    else        state <= state_nx;
  end

  // Next-state logic.
  always_comb begin
    state_nx = state;
    if (bus.stop) begin
      state_nx = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: if (bus.start) state_nx = ST_RUN;
        ST_RUN:  if (hit && oneshot_q) state_nx = ST_DONE;
        ST_DONE: if (bus.start) state_nx = ST_RUN;
        default: state_nx = ST_IDLE;
      endcase
    end
  end

  // Next extension count: cleared on stop/arm, wraps to 0 on match.
  always_comb begin
    cnt_nx = cnt_q;
    if (bus.stop || arm) begin
      cnt_nx = '0;
    end else if (ev) begin
      cnt_nx = (cnt_q == period_q) ? '0 : cnt_q + WIDTH'(1);
    end
  end

  // Output and configuration registers.
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      cnt_q     <= '0;
      tick_q    <= 1'b0;
      busy_q    <= 1'b0;
      period_q  <= '0;
      oneshot_q <= 1'b0;
      cap_q     <= '0;
      cap_vld_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_nx;
      tick_q    <= hit;
      busy_q    <= (state_nx == ST_RUN);
      cap_vld_q <= bus.capture_req;
      if (arm) begin
        period_q  <= bus.period;
        oneshot_q <= bus.oneshot;
      end
      // Pre-edge count, so a coincident carry is seen before its increment.
      if (bus.capture_req) cap_q <= {cnt_q, nib_val(bus.nibble_in)};
    end
  end

  irq_latch u_irq (
    .clock  (clock),
    .clear  (clear),
    .set    (hit),
    .ack    (bus.irq_ack),
    .irq    (bus.irq),
    .missed (bus.missed)
  );

  assign bus.ext_count   = cnt_q;
  assign bus.tick        = tick_q;
  assign bus.busy        = busy_q;
  assign bus.capture     = cap_q;
  assign bus.capture_vld = cap_vld_q;

endmodule

// File: tb/tb_carry_event_timer.sv
module tb_carry_event_timer;

  localparam int W  = 8;
  localparam int NV = 39;

  typedef struct {
    logic         c, e, s, p, o;
    logic [W-1:0] per;
    logic         a, q;
    logic [3:0]   nib;
    logic [W-1:0] cnt;
    logic         busy, tick, irq, mis, cvld;
    logic [W+3:0] cap;
  } vec_t;

  logic clock;
  logic clear;
  int   errors;
  int   checks;
  vec_t vecs [NV];

  carry_event_timer_if #(.WIDTH(W)) bus ();

  carry_event_timer #(.WIDTH(W)) dut (
    .clock (clock),
    .clear (clear),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end

  function automatic vec_t mk(input logic c, e, s, p, o, input logic [W-1:0] per,
                              input logic a, q, input logic [3:0] nib,
                              input logic [W-1:0] cnt, input logic busy, tick, irq, mis, cvld,
                              input logic [W+3:0] cap);
    vec_t v;
    v.c = c; v.e = e; v.s = s; v.p = p; v.o = o; v.per = per;
    v.a = a; v.q = q; v.nib = nib;
    v.cnt = cnt; v.busy = busy; v.tick = tick; v.irq = irq; v.mis = mis;
    v.cvld = cvld; v.cap = cap;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    bus.carry_in    = v.c;
    bus.enable      = v.e;
    bus.start       = v.s;
    bus.stop        = v.p;
    bus.oneshot     = v.o;
    bus.period      = v.per;
    bus.irq_ack     = v.a;
    bus.capture_req = v.q;
    for (int i = 0; i < 4; i++) bus.nibble_in[i] = v.nib[i];
  endtask

  // Drive on the falling edge, sample 1 time unit after the rising edge.
  task automatic apply(input vec_t v);
    @(negedge clock);
    drive(v);
    @(posedge clock);
    #1;
  endtask

  task automatic chk_all(input string tag, input vec_t v);
    chk({tag, ".ext_count"},   32'(bus.ext_count),   32'(v.cnt));
    chk({tag, ".busy"},        32'(bus.busy),        32'(v.busy));
    chk({tag, ".tick"},        32'(bus.tick),        32'(v.tick));
    chk({tag, ".irq"},         32'(bus.irq),         32'(v.irq));
    chk({tag, ".missed"},      32'(bus.missed),      32'(v.mis));
    chk({tag, ".capture_vld"}, 32'(bus.capture_vld), 32'(v.cvld));
    chk({tag, ".capture"},     32'(bus.capture),     32'(v.cap));
  endtask

  vec_t idle;
  logic seen_tick;

  initial begin
    errors = 0;
    checks = 0;
    idle   = mk(0,0,0,0,0,0,0,0,0, 0,0,0,0,0,0,0);

    //         c e s p o per a q nib   cnt bsy tk irq ms cv cap
    vecs[0]  = mk(0,0,1,1,0,3, 0,0,0,  0,0,0,0,0,0,12'h000); // start+stop: stay IDLE
    vecs[1]  = mk(1,1,0,0,0,0, 0,0,0,  0,0,0,0,0,0,12'h000); // carry ignored in IDLE
    vecs[2]  = mk(0,0,1,0,0,3, 0,0,0,  0,1,0,0,0,0,12'h000); // start period=3
    vecs[3]  = mk(1,1,0,0,0,0, 0,0,0,  1,1,0,0,0,0,12'h000);
    vecs[4]  = mk(1,1,0,0,0,0, 0,0,0,  2,1,0,0,0,0,12'h000);
    vecs[5]  = mk(1,1,0,0,0,0, 0,0,0,  3,1,0,0,0,0,12'h000);
    vecs[6]  = mk(1,1,0,0,0,0, 0,0,0,  0,1,1,1,0,0,12'h000); // match: tick, irq
    vecs[7]  = mk(0,0,0,0,0,0, 0,0,0,  0,1,0,1,0,0,12'h000); // tick one cycle only
    vecs[8]  = mk(1,0,0,0,0,0, 0,0,0,  0,1,0,1,0,0,12'h000); // enable=0 blocks carry
    vecs[9]  = mk(0,0,0,0,0,0, 1,0,0,  0,1,0,0,0,0,12'h000); // ack clears irq
    vecs[10] = mk(0,0,1,0,0,0, 0,0,0,  0,1,0,0,0,0,12'h000); // start in RUN ignored
    vecs[11] = mk(1,1,0,0,0,0, 0,0,0,  1,1,0,0,0,0,12'h000); // period still 3
    vecs[12] = mk(0,0,0,1,0,0, 0,0,0,  0,0,0,0,0,0,12'h000); // stop
    vecs[13] = mk(0,0,1,0,0,0, 0,0,0,  0,1,0,0,0,0,12'h000); // start period=0
    vecs[14] = mk(1,1,0,0,0,0, 0,0,0,  0,1,1,1,0,0,12'h000);
    vecs[15] = mk(1,1,0,0,0,0, 0,0,0,  0,1,1,1,1,0,12'h000); // tick while pending: missed
    vecs[16] = mk(1,1,0,0,0,0, 1,0,0,  0,1,1,1,0,0,12'h000); // tick+ack: irq stays, missed 0
    vecs[17] = mk(0,0,0,0,0,0, 1,0,0,  0,1,0,0,0,0,12'h000);
    vecs[18] = mk(0,0,0,1,0,0, 0,0,0,  0,0,0,0,0,0,12'h000);
    vecs[19] = mk(0,0,1,0,0,10,0,0,0,  0,1,0,0,0,0,12'h000); // start period=10
    vecs[20] = mk(1,1,0,0,0,0, 0,0,0,  1,1,0,0,0,0,12'h000);
    vecs[21] = mk(1,1,0,0,0,0, 0,0,0,  2,1,0,0,0,0,12'h000);
    vecs[22] = mk(1,1,0,0,0,0, 0,0,0,  3,1,0,0,0,0,12'h000);
    vecs[23] = mk(1,1,0,0,0,0, 0,0,0,  4,1,0,0,0,0,12'h000);
    vecs[24] = mk(1,1,0,0,0,0, 0,0,0,  5,1,0,0,0,0,12'h000);
    vecs[25] = mk(1,1,0,0,0,0, 0,1,4'hF, 6,1,0,0,0,1,12'h05F); // capture pre-increment
    vecs[26] = mk(0,0,0,0,0,0, 0,1,4'h1, 6,1,0,0,0,1,12'h061); // nibble bit 0 is LSB
    vecs[27] = mk(0,0,0,0,0,0, 0,0,0,  6,1,0,0,0,0,12'h061); // capture holds
    vecs[28] = mk(1,1,0,0,0,0, 0,0,0,  7,1,0,0,0,0,12'h061);
    vecs[29] = mk(0,0,0,1,0,0, 0,0,0,  0,0,0,0,0,0,12'h061); // stop at 7
    vecs[30] = mk(0,0,1,0,1,0, 0,0,0,  0,1,0,0,0,0,12'h061); // oneshot, period=0
    vecs[31] = mk(1,1,0,0,0,0, 0,0,0,  0,0,1,1,0,0,12'h061); // DONE
    vecs[32] = mk(1,1,0,0,0,0, 0,0,0,  0,0,0,1,0,0,12'h061); // ignored in DONE
    vecs[33] = mk(0,0,0,0,0,0, 0,1,4'h4, 0,0,0,1,0,1,12'h004); // capture in DONE
    vecs[34] = mk(0,0,1,0,0,2, 0,0,0,  0,1,0,1,0,0,12'h004); // restart from DONE
    vecs[35] = mk(0,0,0,0,0,0, 1,0,0,  0,1,0,0,0,0,12'h004);
    vecs[36] = mk(1,1,0,0,0,0, 0,0,0,  1,1,0,0,0,0,12'h004);
    vecs[37] = mk(1,1,0,0,0,0, 0,0,0,  2,1,0,0,0,0,12'h004);
    vecs[38] = mk(1,1,0,0,0,0, 0,0,0,  0,1,1,1,0,0,12'h004); // not oneshot any more

    // Reset state.
    clear = 1'b0;
    drive(idle);
    repeat (2) @(negedge clock);
    chk_all("reset", idle);
    clear = 1'b1;

    for (int i = 0; i < NV; i++) begin
      apply(vecs[i]);
      chk_all($sformatf("v%0d", i), vecs[i]);
    end

    // Asynchronous reset mid-RUN with irq pending and a fresh capture.
    apply(mk(1,1,0,0,0,0, 0,1,4'h3, 0,0,0,0,0,0,0));
    chk("pre_rst.ext_count",   32'(bus.ext_count),   32'd1);
    chk("pre_rst.irq",         32'(bus.irq),         32'd1);
    chk("pre_rst.capture_vld", 32'(bus.capture_vld), 32'd1);
    chk("pre_rst.capture",     32'(bus.capture),     32'h003);
    @(negedge clock);
    drive(idle);
    #2 clear = 1'b0;
    #1 chk_all("async_rst", idle);
    @(negedge clock);
    clear = 1'b1;
    for (int i = 0; i < 3; i++) begin
      apply(mk(1,1,0,0,0,0, 0,0,0, 0,0,0,0,0,0,0));
      chk_all($sformatf("post_rst%0d", i), idle);
    end

    // Full-range period: no tick until the 256th carry, then wrap to 0.
    apply(mk(0,0,1,0,0,8'hFF, 0,0,0, 0,0,0,0,0,0,0));
    chk("full.busy", 32'(bus.busy), 32'd1);
    seen_tick = 1'b0;
    for (int i = 1; i <= 255; i++) begin
      apply(mk(1,1,0,0,0,0, 0,0,0, 0,0,0,0,0,0,0));
      if (bus.tick) seen_tick = 1'b1;
    end
    chk("full.cnt255",  32'(bus.ext_count), 32'd255);
    chk("full.no_tick", 32'(seen_tick),     32'd0);
    chk("full.no_irq",  32'(bus.irq),       32'd0);
    apply(mk(1,1,0,0,0,0, 0,0,0, 0,0,0,0,0,0,0));
    chk("full.wrap_cnt",  32'(bus.ext_count), 32'd0);
    chk("full.wrap_tick", 32'(bus.tick),      32'd1);
    chk("full.wrap_irq",  32'(bus.irq),       32'd1);
    chk("full.wrap_busy", 32'(bus.busy),      32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
